// File: rtl/sdcard_pin_irq.sv
// Pin-change interrupt controller: per-channel 2-flop synchroniser, debounce,
// edge-enabled sticky pending bits (write-1-to-clear) and a single irq output.
module sdcard_pin_irq #(
    parameter int CHANNELS  = 4,
    parameter int DB_W      = 16,
    parameter int DB_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                select,
    input  logic [1:0]          addr,
    input  logic [3:0]          we,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    output logic                irq,
    input  logic [CHANNELS-1:0] pins
);

    localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DB_CYCLES - 1);
    localparam logic [1:0]      REG_STATUS  = 2'd0;
    localparam logic [1:0]      REG_LEVEL   = 2'd1;
    localparam logic [1:0]      REG_RISE_EN = 2'd2;
    localparam logic [1:0]      REG_FALL_EN = 2'd3;

    logic [CHANNELS-1:0] sync_p0;
    logic [CHANNELS-1:0] sync_p1;
    logic [CHANNELS-1:0] stable;
    logic [CHANNELS-1:0] armed;
    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] rise_en;
    logic [CHANNELS-1:0] fall_en;
    logic [DB_W-1:0]     cnt     [CHANNELS];
    logic [DB_W-1:0]     cnt_nxt [CHANNELS];

    logic [CHANNELS-1:0] qual;
    logic [CHANNELS-1:0] edge_ev;
    logic [CHANNELS-1:0] rise_ev;
    logic [CHANNELS-1:0] fall_ev;
    logic [CHANNELS-1:0] lane_hit;
    logic [CHANNELS-1:0] clr_bits;
    logic [CHANNELS-1:0] pending_nxt;
    logic                unused_bus;

    // Register bit b lives in byte lane b/8.
    function automatic logic [CHANNELS-1:0] lane_bits(input logic [3:0] lanes);
        logic [CHANNELS-1:0] m;
        for (int b = 0; b < CHANNELS; b++) begin
            m[b] = lanes[b >> 3];
        end
        return m;
    endfunction

    assign unused_bus = ^{wdata, we};

    always_comb begin
        lane_hit = select ? lane_bits(we) : '0;
        clr_bits = (addr == REG_STATUS) ? (lane_hit & wdata[CHANNELS-1:0]) : '0;
        qual     = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_nxt[i] = cnt[i] + 1'b1;
            // Unarmed channels count cycles since reset regardless of level.
            qual[i] = (cnt[i] == DB_LAST) && (!armed[i] || (sync_p1[i] != stable[i]));
            if (qual[i] || (armed[i] && (sync_p1[i] == stable[i]))) begin
                cnt_nxt[i] = '0;
            end
        end
        edge_ev     = qual & armed;
        rise_ev     = edge_ev & sync_p1 & rise_en;
        fall_ev     = edge_ev & ~sync_p1 & fall_en;
        pending_nxt = (pending & ~clr_bits) | rise_ev | fall_ev;
    end

    always_comb begin
        rdata = '0;
        case (addr)
            REG_STATUS:  rdata[CHANNELS-1:0] = pending;
            REG_LEVEL:   rdata[CHANNELS-1:0] = stable;
            REG_RISE_EN: rdata[CHANNELS-1:0] = rise_en;
            REG_FALL_EN: rdata[CHANNELS-1:0] = fall_en;
            default:     rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            stable  <= '0;
            armed   <= '0;
            pending <= '0;
            rise_en <= '0;
            fall_en <= '0;
            irq     <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            // stage p0 -> p1: synchroniser
            sync_p0 <= pins;
            sync_p1 <= sync_p0;
            // debounce and event stage
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            stable  <= (stable & ~qual) | (sync_p1 & qual);
            armed   <= armed | qual;
            pending <= pending_nxt;
            irq     <= |pending_nxt;
            if (addr == REG_RISE_EN) begin
                rise_en <= (rise_en & ~lane_hit) | (wdata[CHANNELS-1:0] & lane_hit);
            end
            if (addr == REG_FALL_EN) begin
                fall_en <= (fall_en & ~lane_hit) | (wdata[CHANNELS-1:0] & lane_hit);
            end
        end
    end

endmodule

// File: tb/tb_sdcard_pin_irq.sv
// Bench for sdcard_pin_irq: directed scenarios plus randomized pins/bus traffic
// checked against a window-based behavioural model.
module tb_sdcard_pin_irq;

    localparam int CH   = 4;
    localparam int DBW  = 8;
    localparam int DBC  = 8;
    localparam int MAXE = 4096;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          select;
    logic [1:0]    addr;
    logic [3:0]    we;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          irq;
    logic [CH-1:0] pins;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: levels change once the last DBC synchronised samples all
    // disagree with the accepted level (and DBC edges passed since last change).
    logic [CH-1:0] m_stable, m_armed, m_pend, m_rise, m_fall;
    int            m_k;
    int            m_last [CH];
    logic [CH-1:0] plog [0:MAXE];
    logic [CH-1:0] sh   [0:MAXE];

    sdcard_pin_irq #(.CHANNELS(CH), .DB_W(DBW), .DB_CYCLES(DBC)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .select (select),
        .addr   (addr),
        .we     (we),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq),
        .pins   (pins)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_k = 0;
        m_stable = '0; m_armed = '0; m_pend = '0; m_rise = '0; m_fall = '0;
        for (int i = 0; i < CH; i++) m_last[i] = 0;
    endtask

    task automatic model_step(input logic [CH-1:0] p, input logic sel, input logic [1:0] a,
                              input logic [3:0] w, input logic [31:0] d);
        logic [CH-1:0] s, lm, clr, ev, nst, narm;
        bit all_diff;
        m_k++;
        if (m_k >= MAXE) begin
            $display("FAIL model_depth: got %0d expected below %0d", m_k, MAXE);
            $fatal(1, "model history exhausted");
        end
        plog[m_k] = p;
        s = (m_k >= 3) ? plog[m_k-2] : '0;
        sh[m_k] = s;
        for (int b = 0; b < CH; b++) lm[b] = sel & w[b/8];
        clr  = (a == 2'd0) ? (lm & d[CH-1:0]) : '0;
        ev   = '0;
        nst  = m_stable;
        narm = m_armed;
        for (int i = 0; i < CH; i++) begin
            if (!m_armed[i]) begin
                if (m_k == DBC) begin
                    nst[i] = s[i]; narm[i] = 1'b1; m_last[i] = m_k;
                end
            end else if (m_k - m_last[i] >= DBC) begin
                all_diff = 1;
                for (int j = m_k - DBC + 1; j <= m_k; j++)
                    if (sh[j][i] == m_stable[i]) all_diff = 0;
                if (all_diff) begin
                    nst[i] = s[i];
                    m_last[i] = m_k;
                    ev[i] = s[i] ? m_rise[i] : m_fall[i];
                end
            end
        end
        m_pend = (m_pend & ~clr) | ev;
        if (a == 2'd2) m_rise = (m_rise & ~lm) | (d[CH-1:0] & lm);
        if (a == 2'd3) m_fall = (m_fall & ~lm) | (d[CH-1:0] & lm);
        m_stable = nst;
        m_armed  = narm;
    endtask

    task automatic check_regs();
        addr = 2'd0; #1; chk("status",  rdata, 32'(m_pend));
        addr = 2'd1; #1; chk("level",   rdata, 32'(m_stable));
        addr = 2'd2; #1; chk("rise_en", rdata, 32'(m_rise));
        addr = 2'd3; #1; chk("fall_en", rdata, 32'(m_fall));
        chk("irq", 32'(irq), 32'(|m_pend));
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        addr = a; #1; v = rdata;
    endtask

    task automatic tick();
        logic [CH-1:0] p  = pins;
        logic          sl = select;
        logic [1:0]    a  = addr;
        logic [3:0]    w  = we;
        logic [31:0]   d  = wdata;
        logic          rn = reset_n;
        @(posedge clk); #1;
        if (rn) model_step(p, sl, a, w, d);
        select = 1'b0; we = 4'h0;
        check_regs();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] w, input logic [31:0] d);
        select = 1'b1; addr = a; we = w; wdata = d;
        tick();
    endtask

    logic [31:0] v;

    initial begin
        reset_n = 1'b0; select = 1'b0; addr = 2'd0; we = 4'h0; wdata = '0;
        pins = 4'b0001;
        model_reset();
        ticks(3);
        reset_n = 1'b1;

        // Power-up with a pin already high: level follows, no interrupt.
        wr(2'd2, 4'h1, 32'hF);
        ticks(9);
        rd(2'd1, v); chk("pwrup_level", v, 32'h1);
        rd(2'd0, v); chk("pwrup_status", v, 32'h0);
        chk("pwrup_irq", 32'(irq), 32'h0);

        // Armed rising edge: pending exactly 2+DBC cycles after the pin change.
        wr(2'd2, 4'h1, 32'h2);
        pins[1] = 1'b1;
        ticks(9);
        chk("rise_early_irq", 32'(irq), 32'h0);
        tick();
        chk("rise_irq", 32'(irq), 32'h1);
        rd(2'd0, v); chk("rise_status", v, 32'h2);
        rd(2'd1, v); chk("rise_level", v, 32'h3);

        // Glitch shorter than DBC is ignored.
        wr(2'd3, 4'h1, 32'hF);
        wr(2'd2, 4'h1, 32'hF);
        pins[2] = 1'b1; ticks(5);
        pins[2] = 1'b0; ticks(15);
        rd(2'd1, v); chk("glitch_level", v, 32'h3);
        rd(2'd0, v); chk("glitch_status", v, 32'h2);
        chk("glitch_irq", 32'(irq), 32'h1);

        // Write-1-to-clear.
        pins[2] = 1'b1; ticks(12);
        rd(2'd0, v); chk("w1c_pre", v, 32'h6);
        wr(2'd0, 4'b0001, 32'h2);
        rd(2'd0, v); chk("w1c_one", v, 32'h4);
        chk("w1c_one_irq", 32'(irq), 32'h1);
        wr(2'd0, 4'b0001, 32'h4);
        rd(2'd0, v); chk("w1c_all", v, 32'h0);
        chk("w1c_all_irq", 32'(irq), 32'h0);

        // Clear and fall event on the same edge: set wins.
        pins[3] = 1'b1; ticks(12);
        rd(2'd0, v); chk("sim_pre", v, 32'h8);
        pins[3] = 1'b0; ticks(9);
        wr(2'd0, 4'b0001, 32'h8);
        rd(2'd0, v); chk("sim_setwins", v, 32'h8);
        rd(2'd1, v); chk("sim_level", v, 32'h7);
        wr(2'd0, 4'b0001, 32'h8);
        rd(2'd0, v); chk("sim_clear", v, 32'h0);

        // Byte lanes, select gating, read-only LEVEL.
        wr(2'd2, 4'b0001, 32'h5);
        rd(2'd2, v); chk("lane_set", v, 32'h5);
        wr(2'd2, 4'b0000, 32'hFFFF_FFFF);
        rd(2'd2, v); chk("lane_none", v, 32'h5);
        wr(2'd2, 4'b1110, 32'hFFFF_FFFF);
        rd(2'd2, v); chk("lane_upper", v, 32'h5);
        select = 1'b0; addr = 2'd2; we = 4'hF; wdata = 32'h0;
        tick();
        rd(2'd2, v); chk("no_select", v, 32'h5);
        wr(2'd1, 4'hF, 32'h0);
        rd(2'd1, v); chk("level_ro", v, 32'h7);

        // Reset mid-debounce with pending set.
        wr(2'd2, 4'b0001, 32'hF);
        pins[3] = 1'b1; ticks(12);
        rd(2'd0, v); chk("mrst_pre", v, 32'h8);
        pins[0] = 1'b0; ticks(7);
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("mrst_irq", 32'(irq), 32'h0);
        rd(2'd0, v); chk("mrst_status", v, 32'h0);
        rd(2'd1, v); chk("mrst_level", v, 32'h0);
        rd(2'd2, v); chk("mrst_rise", v, 32'h0);
        rd(2'd3, v); chk("mrst_fall", v, 32'h0);
        ticks(3);
        reset_n = 1'b1;

        // Randomized traffic.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < CH; i++)
                if ($urandom_range(0, 11) == 0) pins[i] = ~pins[i];
            select = ($urandom_range(0, 2) == 0);
            addr   = 2'($urandom_range(0, 3));
            we     = 4'($urandom);
            wdata  = $urandom;
            tick();
            if (cyc % 700 == 350) begin
                reset_n = 1'b0;
                model_reset();
                check_regs();
                ticks(2);
                reset_n = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
